note_sequencer: RTL
===================

Name: note_sequencer

Overview:
Pattern sequencer that drives the tone generator's frequency word and waveform one-hot select. It holds a small programmable table of notes (frequency, waveform, duration) and steps through it on a millisecond-scale tick. It handles start, stop, loop and end-of-pattern. It sits between the host/switch logic and the frequency-controlled wave generator, and replaces static freq/switch inputs.

Parameters:
steps_p, 16, number of pattern entries (power of 2, >=2)
clk_freq_p, 12_000_000, input clock frequency in Hz
tick_hz_p, 1000, duration tick rate in Hz; div_lp = clk_freq_p/tick_hz_p clock cycles per tick
dur_width_p, 8, width of per-note duration field, in ticks

Ports:
clk_i  in  1  clock, all logic on rising edge
reset_i  in  1  asynchronous, active-high reset
start_i  in  1  begin playback at step 0 (level-sampled; ignored while busy_o=1)
stop_i  in  1  abort playback; priority over start_i
loop_i  in  1  1: restart at step 0 after pattern end; sampled at end of pattern
wr_en_i  in  1  write one pattern entry
wr_addr_i  in  $clog2(steps_p)  entry index
wr_freq_i  in  16  note frequency in Hz (20..20000)
wr_sw_i  in  4  one-hot waveform select (sine/square/triangle/saw)
wr_dur_i  in  dur_width_p  duration in ticks; 0 = end-of-pattern marker
freq_o  out  16  frequency word to the generator
sw_o  out  4  waveform select to the generator; 0 = silence
step_o  out  $clog2(steps_p)  index of the current entry
busy_o  out  1  high in LOAD/PLAY
note_stb_o  out  1  one-cycle pulse when a new note is applied
done_o  out  1  one-cycle pulse at natural pattern end (not on stop)

Behaviour:
- Reset (async): state IDLE; freq_o=0, sw_o=0, step_o=0, busy_o=0, note_stb_o=0, done_o=0. All entry valid bits are cleared. Tick and duration counters are cleared. Table data is not reset.
- Write: at an edge with wr_en_i=1, the table stores {freq, sw, dur} at wr_addr_i and sets valid. Writes are allowed in any state. A write to the playing entry takes effect only at that entry's next LOAD.
- States: IDLE, LOAD, PLAY.
- IDLE: if start_i=1 and stop_i=0, go to LOAD with step_o=0 and busy_o=1.
- LOAD (exactly 1 cycle): read table[step_o].
  - Entry valid and dur!=0: on the next edge, register freq_o/sw_o, pulse note_stb_o, load the duration counter with dur, clear the tick counter, go to PLAY.
  - Entry invalid or dur=0 (end marker):
    - loop_i=1 and step_o!=0: set step_o=0 and stay in LOAD (one extra cycle).
    - Otherwise: on the next edge set freq_o=0, sw_o=0, pulse done_o, go to IDLE, busy_o=0.
- PLAY: tick counter counts 0..div_lp-1 and wraps; each wrap decrements the duration counter. When a wrap occurs with counter==1, go to LOAD with step_o+1.
  - step_o==steps_p-1 wraps to 0. This is treated as pattern end: loop_i=1 loads step 0; loop_i=0 emits done_o as for an end marker.
- Timing:
  - start_i sampled at edge k gives note_stb_o and new freq_o at edge k+2.
  - Consecutive note_stb_o pulses are spaced dur*div_lp+1 cycles apart (1 = LOAD cycle).
  - Loop via end marker adds one more cycle.
- stop_i=1 in any state: on the next edge go to IDLE, freq_o=0, sw_o=0, busy_o=0, step_o=0, counters cleared, no done_o.
- start_i while busy_o=1 is ignored. start_i and stop_i together: stop wins.
- Counters saturate nowhere. The duration counter is dur_width_p bits. The tick counter is $clog2(div_lp) bits.

Optional Feature:
SEQ_GATE_GAP_EN
- Defined: during the final tick period of any note with dur>=2, sw_o is forced to 0 while freq_o is held (articulation gap). sw_o is restored at the next note_stb_o. Notes with dur=1 get no gap.
- Undefined: sw_o holds the entry value for the whole note.

Test Plan:
(Params for all scenarios: clk_freq_p=100, tick_hz_p=10, so div_lp=10.)
- Program {440,0001,2},{880,0010,1},{x,x,0}; loop_i=0; start at edge k -> stb at k+2 (440/0001), k+23 (880/0010); done_o at k+34 with sw_o=0 and freq_o=0; busy_o low from k+34.
- Same pattern, loop_i=1 -> stb at k+2, k+23, then 440/0001 again at k+35; no done_o.
- stop_i pulsed 5 cycles after the first stb -> next edge: sw_o=0, freq_o=0, busy_o=0, step_o=0; no done_o; start_i afterwards replays from step 0.
- All 16 entries valid with dur=1, loop_i=0 -> 16 stb pulses spaced 11 cycles apart, step_o 0..15, done_o 11 cycles after the 16th stb.
- Empty table (after reset), start_i -> done_o at k+2, no note_stb_o, sw_o stays 0; reset_i asserted mid-note -> all outputs 0 immediately (asynchronous), and a subsequent start gives done_o only (valid bits cleared).

Source files
------------

// File: rtl/note_sequencer_if.sv
// Host-side bus of the note sequencer: playback control, table write port
// and the frequency/waveform outputs that feed the tone generator.
// master = host/switch logic, slave = note_sequencer.
interface note_sequencer_if #(
   parameter int steps_p     = 16,
   parameter int dur_width_p = 8
);
   localparam int addr_w_lp = $clog2(steps_p);

   logic                   start_i;
   logic                   stop_i;
   logic                   loop_i;
   logic                   wr_en_i;
   logic [addr_w_lp-1:0]   wr_addr_i;
   logic [15:0]            wr_freq_i;
   logic [3:0]             wr_sw_i;
   logic [dur_width_p-1:0] wr_dur_i;
   logic [15:0]            freq_o;
   logic [3:0]             sw_o;
   logic [addr_w_lp-1:0]   step_o;
   logic                   busy_o;
   logic                   note_stb_o;
   logic                   done_o;

   modport master (
      output start_i, stop_i, loop_i, wr_en_i, wr_addr_i, wr_freq_i, wr_sw_i, wr_dur_i,
      input  freq_o, sw_o, step_o, busy_o, note_stb_o, done_o
   );

   modport slave (
      input  start_i, stop_i, loop_i, wr_en_i, wr_addr_i, wr_freq_i, wr_sw_i, wr_dur_i,
      output freq_o, sw_o, step_o, busy_o, note_stb_o, done_o
   );
endinterface

// File: rtl/note_sequencer.sv
// Note pattern sequencer: steps through a programmable table of
// {frequency, one-hot waveform, duration} entries on a millisecond-scale
// tick and drives the tone generator's frequency word and waveform select.
// Optional build macro SEQ_GATE_GAP_EN: silences sw_o during the last tick
// period of every note that lasts two or more ticks (articulation gap).
module note_sequencer #(
   parameter int steps_p     = 16,
   parameter int clk_freq_p  = 12_000_000,
   parameter int tick_hz_p   = 1000,
   parameter int dur_width_p = 8
) (
   input  logic            clk_i,
   input  logic            reset_i,
   note_sequencer_if.slave bus
);
   localparam int div_lp    = clk_freq_p / tick_hz_p;
   localparam int addr_w_lp = $clog2(steps_p);
   localparam int tick_w_lp = (div_lp > 1) ? $clog2(div_lp) : 1;

   localparam logic [tick_w_lp-1:0]   tick_last_lp = tick_w_lp'(div_lp - 1);
   localparam logic [tick_w_lp-1:0]   tick_one_lp  = tick_w_lp'(1);
   localparam logic [addr_w_lp-1:0]   step_last_lp = addr_w_lp'(steps_p - 1);
   localparam logic [addr_w_lp-1:0]   step_one_lp  = addr_w_lp'(1);
   localparam logic [dur_width_p-1:0] dur_one_lp   = dur_width_p'(1);
`ifdef SEQ_GATE_GAP_EN
   localparam logic [dur_width_p-1:0] dur_two_lp   = dur_width_p'(2);
`endif

   typedef enum logic [1:0] {IDLE, LOAD, PLAY} state_e;

   // Pattern table; data words are never reset, only the valid bits are
   logic [15:0]            tbl_freq_q [steps_p];
   logic [3:0]             tbl_sw_q   [steps_p];
   logic [dur_width_p-1:0] tbl_dur_q  [steps_p];
   logic [steps_p-1:0]     tbl_vld_q, tbl_vld_d;

   state_e                 state_q, state_d;
   logic [15:0]            freq_q, freq_d;
   logic [3:0]             sw_q, sw_d;
   logic [addr_w_lp-1:0]   step_q, step_d;
   logic                   busy_q, busy_d;
   logic                   stb_q, stb_d;
   logic                   done_q, done_d;
   logic [tick_w_lp-1:0]   tick_q, tick_d;
   logic [dur_width_p-1:0] dur_q, dur_d;
   // Set when playback stepped past the last entry; LOAD treats it as pattern end
   logic                   wrap_q, wrap_d;
   // start_i is registered once before the FSM acts on it
   logic                   start_q, start_d;

   logic                   rd_vld;
   logic [15:0]            rd_freq;
   logic [3:0]             rd_sw;
   logic [dur_width_p-1:0] rd_dur;
   logic                   finish_pat;

   assign rd_vld  = tbl_vld_q[step_q];
   assign rd_freq = tbl_freq_q[step_q];
   assign rd_sw   = tbl_sw_q[step_q];
   assign rd_dur  = tbl_dur_q[step_q];

   // Table write port data: stored at any time, picked up at the entry's next LOAD
   always_ff @(posedge clk_i) begin
      if (bus.wr_en_i) begin
         tbl_freq_q[bus.wr_addr_i] <= bus.wr_freq_i;
         tbl_sw_q[bus.wr_addr_i]   <= bus.wr_sw_i;
         tbl_dur_q[bus.wr_addr_i]  <= bus.wr_dur_i;
      end
   end

   // Valid bit of an entry is set by its first write
   always_comb begin
      tbl_vld_d = tbl_vld_q;
      if (bus.wr_en_i) begin
         tbl_vld_d[bus.wr_addr_i] = 1'b1;
      end
   end

   // Sequencer next-state: stop overrides everything, then IDLE/LOAD/PLAY
   always_comb begin
      state_d    = state_q;
      freq_d     = freq_q;
      sw_d       = sw_q;
      step_d     = step_q;
      busy_d     = busy_q;
      stb_d      = 1'b0;
      done_d     = 1'b0;
      tick_d     = tick_q;
      dur_d      = dur_q;
      wrap_d     = wrap_q;
      start_d    = bus.start_i & ~bus.stop_i;
      finish_pat = 1'b0;

      if (bus.stop_i) begin
         state_d = IDLE;
         freq_d  = '0;
         sw_d    = '0;
         step_d  = '0;
         busy_d  = 1'b0;
         tick_d  = '0;
         dur_d   = '0;
         wrap_d  = 1'b0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (start_q) begin
                  state_d = LOAD;
                  step_d  = '0;
                  busy_d  = 1'b1;
                  wrap_d  = 1'b0;
               end
            end
            LOAD: begin
               if (wrap_q && !bus.loop_i) begin
                  finish_pat = 1'b1;
               end else if (rd_vld && (rd_dur != '0)) begin
                  state_d = PLAY;
                  freq_d  = rd_freq;
                  sw_d    = rd_sw;
                  stb_d   = 1'b1;
                  dur_d   = rd_dur;
                  tick_d  = '0;
                  wrap_d  = 1'b0;
               end else if (bus.loop_i && (step_q != '0)) begin
                  // End marker with looping: rewind and spend one more LOAD cycle
                  step_d = '0;
               end else begin
                  finish_pat = 1'b1;
               end
               if (finish_pat) begin
                  state_d = IDLE;
                  freq_d  = '0;
                  sw_d    = '0;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
                  wrap_d  = 1'b0;
               end
            end
            PLAY: begin
               if (tick_q == tick_last_lp) begin
                  tick_d = '0;
                  dur_d  = dur_q - dur_one_lp;
                  if (dur_q == dur_one_lp) begin
                     state_d = LOAD;
                     step_d  = step_q + step_one_lp;
                     wrap_d  = (step_q == step_last_lp);
                  end
`ifdef SEQ_GATE_GAP_EN
                  // Entering the final tick period of a note of two or more ticks
                  if (dur_q == dur_two_lp) begin
                     sw_d = '0;
                  end
`endif
               end else begin
                  tick_d = tick_q + tick_one_lp;
               end
            end
            default: begin
               state_d = IDLE;
               busy_d  = 1'b0;
            end
         endcase
      end
   end

   // State, registered outputs and counters
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_q   <= IDLE;
         freq_q    <= '0;
         sw_q      <= '0;
         step_q    <= '0;
         busy_q    <= 1'b0;
         stb_q     <= 1'b0;
         done_q    <= 1'b0;
         tick_q    <= '0;
         dur_q     <= '0;
         wrap_q    <= 1'b0;
         start_q   <= 1'b0;
         tbl_vld_q <= '0;
      end else begin
         state_q   <= state_d;
         freq_q    <= freq_d;
         sw_q      <= sw_d;
         step_q    <= step_d;
         busy_q    <= busy_d;
         stb_q     <= stb_d;
         done_q    <= done_d;
         tick_q    <= tick_d;
         dur_q     <= dur_d;
         wrap_q    <= wrap_d;
         start_q   <= start_d;
         tbl_vld_q <= tbl_vld_d;
      end
   end

   assign bus.freq_o     = freq_q;
   assign bus.sw_o       = sw_q;
   assign bus.step_o     = step_q;
   assign bus.busy_o     = busy_q;
   assign bus.note_stb_o = stb_q;
   assign bus.done_o     = done_q;
endmodule
